// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, one stop bit, no parity.
// The line is oversampled by CLKS_PER_BIT clocks per bit. The start bit is
// qualified at its midpoint. Data and stop bits are sampled one full bit
// later each, so the stop bit is sampled at its middle. That leaves half a
// bit of idle time to catch a back-to-back start edge.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic             rx_p0;
    logic             rx_p1;
    logic             rx_s;
    logic             rx_prev;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    assign rx_s = rx_p1;
    assign busy = (state != S_IDLE);

    // Two-flop synchronizer plus a delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_p0   <= 1'b1;
            rx_p1   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_p0   <= rx;
            rx_p1   <= rx_p0;
            rx_prev <= rx_p1;
        end
    end

    // Frame state machine, bit timing, shift register and output pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        cnt   <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            bit_idx <= 3'd0;
                            state   <= S_DATA;
                        end else begin
                            // A pulse shorter than half a bit is a glitch, not a start bit.
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data  <= shift;
                            valid <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    // Stay here while the line is held low so a long break reports once.
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at CLKS_PER_BIT = 16.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int busy_cnt = 0;
    int both_cnt = 0;
    int vcyc[$];
    logic [7:0] vdata[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            vcyc.push_back(cyc);
            vdata.push_back(data);
        end
        if (frame_err) ferr_cnt++;
        if (valid && frame_err) both_cnt++;
        if (busy && !reset) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Call right after a negedge; the line is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    int t0, v0, f0, b0, n0, lat;

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", {24'd0, data}, 32'h00);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        idle(10);

        // Single good frame 0xA5 and its latency from the start edge.
        v0 = valid_cnt; f0 = ferr_cnt; n0 = vcyc.size();
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        idle(20);
        chk("a5_valid", valid_cnt - v0, 1);
        chk("a5_data", {24'd0, data}, 32'hA5);
        chk("a5_ferr", ferr_cnt - f0, 0);
        lat = (vcyc.size() > n0) ? vcyc[n0] - t0 : 0;
        chk("a5_latency", (lat >= 154 && lat <= 156), 1);

        // Four-clock glitch must be rejected.
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(30);
        chk("glitch_valid", valid_cnt - v0, 0);
        chk("glitch_ferr", ferr_cnt - f0, 0);
        chk("glitch_busy_max", (busy_cnt - b0 > 0) && (busy_cnt - b0 <= 11), 1);
        chk("glitch_idle", {31'd0, busy}, 32'd0);

        // Good 0x3C, then a framing error on 0x81 followed by a long break.
        v0 = valid_cnt;
        send_frame(8'h3C, 1'b1);
        idle(20);
        chk("3c_valid", valid_cnt - v0, 1);
        chk("3c_data", {24'd0, data}, 32'h3C);
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h81, 1'b0);
        repeat (4) @(negedge clk);
        chk("ferr_pulse", ferr_cnt - f0, 1);
        chk("ferr_no_valid", valid_cnt - v0, 0);
        chk("ferr_data_kept", {24'd0, data}, 32'h3C);
        chk("break_busy", {31'd0, busy}, 32'd1);
        repeat (40 * CPB) @(negedge clk);
        chk("break_one_ferr", ferr_cnt - f0, 1);
        chk("break_busy_long", {31'd0, busy}, 32'd1);
        idle(10);
        chk("break_exit", {31'd0, busy}, 32'd0);

        // Back-to-back 0x00 then 0xFF, no idle gap.
        v0 = valid_cnt; n0 = vcyc.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        chk("b2b_count", valid_cnt - v0, 2);
        if (vcyc.size() >= n0 + 2) begin
            chk("b2b_first", {24'd0, vdata[n0]}, 32'h00);
            chk("b2b_second", {24'd0, vdata[n0+1]}, 32'hFF);
            chk("b2b_spacing", vcyc[n0+1] - vcyc[n0], 160);
        end else begin
            chk("b2b_pulses_seen", vcyc.size() - n0, 2);
        end
        chk("b2b_data", {24'd0, data}, 32'hFF);

        // Reset during data bit 3 aborts the frame; then receive 0x5A.
        v0 = valid_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1; repeat (CPB) @(negedge clk);
        rx = 1'b1; repeat (CPB) @(negedge clk);
        rx = 1'b0; repeat (CPB) @(negedge clk);
        rx = 1'b1; repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_data", {24'd0, data}, 32'h00);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(20);
        chk("abort_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);
        send_frame(8'h5A, 1'b1);
        idle(20);
        chk("5a_valid", valid_cnt - v0, 1);
        chk("5a_data", {24'd0, data}, 32'h5A);
        chk("5a_ferr", ferr_cnt - f0, 0);

        chk("never_both", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 4..65535, even values only.
REQ-002 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: rx  input  1  serial line, asynchronous to clk, idle high; 8 data bits, LSB first, 1 stop bit, no parity.
REQ-005 SHALL have port: data  output  8  last correctly framed byte.
REQ-006 SHALL have port: valid  output  1  one-cycle pulse; data holds a new byte.
REQ-007 SHALL have port: frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-008 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer; all logic uses only the synchronized value (rx_s).
REQ-010 SHALL implement states IDLE, START, DATA, STOP and BREAK, plus one bit-timing counter and a 3-bit bit index.
REQ-011 IDLE: on rx_s high-to-low transition, clear the timing counter and enter START.
REQ-012 START: at counter = CLKS_PER_BIT/2 - 1 (mid start bit), if rx_s = 0 clear the counter and enter DATA with bit index 0; if rx_s = 1 (glitch), return to IDLE with no output pulse.
REQ-013 DATA: at counter = CLKS_PER_BIT - 1, sample rx_s into shift-register position bit index, clear the counter and increment the index; after index 7 is sampled, enter STOP.
REQ-014 STOP: at counter = CLKS_PER_BIT - 1 (mid stop bit), if rx_s = 1, load data from the shift register, pulse valid for exactly one cycle, and enter IDLE.
REQ-015 STOP: if rx_s = 0 at the sample point, pulse frame_err for one cycle, leave data unchanged, and enter BREAK.
REQ-016 BREAK: wait until rx_s = 1, then enter IDLE; a low line held indefinitely produces no further pulses.
REQ-017 Mid-stop sampling SHALL allow a new start edge to be detected half a bit after the stop sample, so back-to-back frames with no idle gap are received.
REQ-018 valid and frame_err SHALL never be high in the same cycle.
REQ-019 data SHALL change only in the cycle valid is asserted.
REQ-020 Overrun is not detected; the consumer must take data within one frame time.
REQ-021 Counter width SHALL be clog2(CLKS_PER_BIT); the counter SHALL never wrap outside the compare points above.

Reset
REQ-022 While reset is high: state = IDLE, data = 0x00, valid = 0, frame_err = 0, busy = 0, both synchronizer flops = 1, counter and bit index = 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, the next falling edge starts a fresh frame.

Verification (CLKS_PER_BIT = 16)
REQ-024 Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> data = 0xA5, one valid pulse about 9.5 bit times (152 clk) plus 2-3 synchronizer cycles after the start edge; frame_err stays 0.
REQ-025 Drive rx low for 4 clk, then high -> returns to IDLE with busy high for at most 8+3 clk; no valid or frame_err pulse.
REQ-026 Receive 0x3C, then a frame with stop bit = 0 and data 0x81 -> one frame_err pulse; data stays 0x3C; BREAK until rx high.
REQ-027 Send 0x00 then 0xFF back-to-back with no idle gap -> two valid pulses 160 clk apart; data = 0x00 then 0xFF.
REQ-028 Assert reset during bit 3 of a frame, release, then send 0x5A -> no pulse from the aborted frame; data = 0x5A with one valid pulse.
REQ-029 Hold rx low for 40 bit times after a frame error -> exactly one frame_err pulse; busy high until rx returns high.
